// File: rtl/sete_segmentos_multi.sv
// Multi-digit 7-segment display driver.
//
// Converts a WIDTH-bit binary value (unsigned or two's complement) into DIGITS
// BCD digits with a sequential double-dabble engine, one shift per clock, and
// drives DIGITS active-low 7-segment patterns with sign and overflow indication.
//
// Optional feature: define SETE_SEG_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked; the minus sign stays in the most-significant digit).
//
// Parameters:
//   WIDTH  - input value width (>= 4)
//   DIGITS - number of displayed digits (>= 1, >= 2 when SIGNED = 1)
//   SIGNED - 1: numero is two's complement, 0: unsigned
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   numero   in   value to display
//   carrega  in   load strobe, ignored while ocupado = 1
//   controle in   display enable; 0 shows a dash on every digit
//   segs     out  active-low segments, digit 0 in segs[6:0], bit 6 = A .. bit 0 = G
//   ocupado  out  conversion in progress
//   pronto   out  one-cycle pulse when a new result reaches segs
//   estouro  out  overflow flag of the last completed conversion
module sete_segmentos_multi #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      numero,
  input  logic                  carrega,
  input  logic                  controle,
  output logic [7*DIGITS-1:0]   segs,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  estouro
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int k = 0; k < n; k++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Largest magnitude that fits; signed builds reserve the top digit for the sign.
  localparam longint unsigned LIMIT = (SIGNED != 0) ? pow10(DIGITS - 1) - 1
                                                    : pow10(DIGITS) - 1;

  // Active-high segment patterns, A..G.
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StUpdate} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;
  logic                estouro_q, estouro_d;
  logic                pronto_q, pronto_d;

  logic                is_neg;
  logic [WIDTH-1:0]    mag;
  logic                over;
  logic [BW-1:0]       bcd_adj;
  logic [7*DIGITS-1:0] segs_new;
  logic                accept;

  assign is_neg = (SIGNED != 0) && numero[WIDTH-1];
  // Negation as WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign mag    = is_neg ? (~numero + {{(WIDTH-1){1'b0}}, 1'b1}) : numero;
  assign over   = 64'(mag) > LIMIT;

  // pronto keeps ocupado high for the cycle after UPDATE, so a load is only
  // accepted once ocupado has actually fallen.
  assign accept = (state_q == StIdle) && !pronto_q && carrega;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Display pattern built from the finished BCD register.
  always_comb begin
    logic [3:0] nib;
    logic [6:0] hi;
`ifdef SETE_SEG_BLANK_EN
    logic       lead;
    lead = 1'b1;
`endif
    segs_new = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      hi  = SEG_BLANK;
      if (ovf_q) begin
        hi = SEG_E;
      end else if (neg_q && (i == DIGITS - 1)) begin
        hi = SEG_DASH;
`ifdef SETE_SEG_BLANK_EN
      end else if (lead && (nib == 4'd0) && (i != 0)) begin
        hi = SEG_BLANK;
      end else begin
        hi   = decode(nib);
        lead = 1'b0;
      end
`else
      end else begin
        hi = decode(nib);
      end
`endif
      segs_new[7*i +: 7] = ~hi;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    segs_d    = segs_q;
    estouro_d = estouro_q;
    pronto_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = mag;
          bcd_d   = '0;
          neg_d   = is_neg;
          ovf_d   = over;
          cnt_d   = CW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        segs_d    = segs_new;
        estouro_d = ovf_q;
        pronto_d  = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      segs_q    <= '1;
      estouro_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      segs_q    <= segs_d;
      estouro_q <= estouro_d;
      pronto_q  <= pronto_d;
    end
  end

  // Display disable is purely combinational; the stored result is untouched.
  assign segs    = controle ? segs_q : {DIGITS{7'b1111110}};
  assign ocupado = (state_q != StIdle) || pronto_q;
  assign pronto  = pronto_q;
  assign estouro = estouro_q;

endmodule
